// File: rtl/fifo_param_sv_pkg.sv
// Shared types and helpers for the parametrised synchronous FIFO.
package fifo_pkg;

  typedef enum logic {
    FIFO_STD  = 1'b0,
    FIFO_FWFT = 1'b1
  } fifo_mode_e;

  // Address width for a given depth; never below 1 so pointer slicing stays legal.
  function automatic int unsigned fifo_aw(input int unsigned depth);
    return (depth < 2) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/fifo_param_sv_if.sv
// Producer/consumer bundle for fifo_param_sv; master drives requests, slave is the FIFO.
interface fifo_param_sv_if
  import fifo_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
);

  localparam int unsigned AW = fifo_aw(DEPTH);

  logic             flush;
  logic             clr_err;
  logic             we;
  logic [WIDTH-1:0] wdata;
  logic             re;
  logic [WIDTH-1:0] rdata;
  logic             full;
  logic             empty;
  logic             almost_full;
  logic             almost_empty;
  logic [AW:0]      count;
  logic             overflow;
  logic             underflow;

  modport master (
    output flush, clr_err, we, wdata, re,
    input  rdata, full, empty, almost_full, almost_empty, count, overflow, underflow
  );

  modport slave (
    input  flush, clr_err, we, wdata, re,
    output rdata, full, empty, almost_full, almost_empty, count, overflow, underflow
  );

endinterface

// File: rtl/fifo_param_sv_ram.sv
// FIFO storage: one synchronous write port, one asynchronous read port, no reset.
module fifo_ram
  import fifo_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16,
  localparam int unsigned AW   = fifo_aw(DEPTH)
) (
  input  logic             i_clk,
  input  logic             i_we,
  input  logic [AW-1:0]    i_waddr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic [AW-1:0]    i_raddr,
  output logic [WIDTH-1:0] o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/fifo_param_sv.sv
// Parametrised single-clock FIFO with occupancy, watermarks, sticky errors, flush and read mode.
module fifo_param_sv
  import fifo_pkg::*;
#(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned DEPTH    = 16,
  parameter int unsigned AF_LEVEL = 12,
  parameter int unsigned AE_LEVEL = 4,
  parameter int unsigned FWFT     = 1
) (
  input  logic           clk,
  input  logic           rst,
  fifo_param_sv_if.slave bus
);

  localparam int unsigned AW     = fifo_aw(DEPTH);
  localparam fifo_mode_e  Mode   = (FWFT != 0) ? FIFO_FWFT : FIFO_STD;
  localparam logic [AW:0] PtrOne = (AW+1)'(1);
  localparam logic [AW:0] AfLvl  = (AW+1)'(AF_LEVEL);
  localparam logic [AW:0] AeLvl  = (AW+1)'(AE_LEVEL);

  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("fifo_param_sv: DEPTH must be a power of two >= 2");
  end
  if ((AF_LEVEL < 1) || (AF_LEVEL > DEPTH)) begin : g_bad_af
    $error("fifo_param_sv: AF_LEVEL must be within 1..DEPTH");
  end
  if (AE_LEVEL > DEPTH - 1) begin : g_bad_ae
    $error("fifo_param_sv: AE_LEVEL must be within 0..DEPTH-1");
  end
  if (WIDTH < 1) begin : g_bad_width
    $error("fifo_param_sv: WIDTH must be >= 1");
  end

  logic [AW:0]      r_wptr, r_rptr, w_wptr_d, w_rptr_d;
  logic             r_ovf, r_udf, w_ovf_d, w_udf_d;
  logic [AW:0]      w_count;
  logic             w_full, w_empty, w_push_ok, w_pop_ok;
  logic [WIDTH-1:0] w_ram_rdata;

  assign w_count = r_wptr - r_rptr;
  assign w_empty = (r_wptr == r_rptr);
  assign w_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);

  // Flush masks both ports so the RAM and the registered read stay untouched.
  assign w_push_ok = bus.we & (~w_full | bus.re) & ~bus.flush;
  assign w_pop_ok  = bus.re & ~w_empty & ~bus.flush;

  always_comb begin
    w_wptr_d = r_wptr;
    w_rptr_d = r_rptr;
    w_ovf_d  = r_ovf & ~bus.clr_err;
    w_udf_d  = r_udf & ~bus.clr_err;
    if (bus.flush) begin
      w_wptr_d = '0;
      w_rptr_d = '0;
    end else begin
      if (w_push_ok) w_wptr_d = r_wptr + PtrOne;
      if (w_pop_ok)  w_rptr_d = r_rptr + PtrOne;
      // Error set wins over a same-cycle clr_err.
      if (bus.we & w_full & ~bus.re) w_ovf_d = 1'b1;
      if (bus.re & w_empty)          w_udf_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_ovf  <= 1'b0;
      r_udf  <= 1'b0;
    end else begin
      r_wptr <= w_wptr_d;
      r_rptr <= w_rptr_d;
      r_ovf  <= w_ovf_d;
      r_udf  <= w_udf_d;
    end
  end

  fifo_ram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_ram (
    .i_clk   (clk),
    .i_we    (w_push_ok),
    .i_waddr (r_wptr[AW-1:0]),
    .i_wdata (bus.wdata),
    .i_raddr (r_rptr[AW-1:0]),
    .o_rdata (w_ram_rdata)
  );

  if (Mode == FIFO_FWFT) begin : g_fwft
    assign bus.rdata = w_ram_rdata;
  end else begin : g_std
    logic [WIDTH-1:0] r_rdata;
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_rdata <= '0;
      end else if (w_pop_ok) begin
        r_rdata <= w_ram_rdata;
      end
    end
    assign bus.rdata = r_rdata;
  end

  assign bus.count        = w_count;
  assign bus.empty        = w_empty;
  assign bus.full         = w_full;
  assign bus.almost_full  = (w_count >= AfLvl);
  assign bus.almost_empty = (w_count <= AeLvl);
  assign bus.overflow     = r_ovf;
  assign bus.underflow    = r_udf;

endmodule

// File: tb/tb_fifo_param_sv.sv
// Scoreboard bench for fifo_param_sv: one FWFT instance and one registered-read instance.
module tb_fifo_param_sv;
  import fifo_pkg::*;

  localparam int unsigned W = 8;
  localparam int unsigned D = 16;

  logic clk = 1'b0;
  logic rst_a, rst_b;
  always #5 clk = ~clk;

  fifo_param_sv_if #(.WIDTH(W), .DEPTH(D)) bus_a ();
  fifo_param_sv_if #(.WIDTH(W), .DEPTH(D)) bus_b ();

  fifo_param_sv #(
    .WIDTH(W), .DEPTH(D), .AF_LEVEL(12), .AE_LEVEL(4), .FWFT(1)
  ) u_dut_a (
    .clk (clk),
    .rst (rst_a),
    .bus (bus_a)
  );

  fifo_param_sv #(
    .WIDTH(W), .DEPTH(D), .AF_LEVEL(12), .AE_LEVEL(4), .FWFT(0)
  ) u_dut_b (
    .clk (clk),
    .rst (rst_b),
    .bus (bus_b)
  );

  int n_checks = 0;
  int n_pass   = 0;
  logic [7:0] exp_a[$];
  logic [7:0] exp_b[$];
  logic pend_b = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
  endtask

  // Drive one cycle on instance A, return 1 time unit after the edge.
  task automatic a_op(input logic we, input logic [7:0] wd, input logic re,
                      input logic fl, input logic ce);
    bus_a.we = we; bus_a.wdata = wd; bus_a.re = re; bus_a.flush = fl; bus_a.clr_err = ce;
    @(posedge clk); #1;
    bus_a.we = 0; bus_a.re = 0; bus_a.flush = 0; bus_a.clr_err = 0;
  endtask

  task automatic b_op(input logic we, input logic [7:0] wd, input logic re,
                      input logic fl, input logic ce);
    bus_b.we = we; bus_b.wdata = wd; bus_b.re = re; bus_b.flush = fl; bus_b.clr_err = ce;
    @(posedge clk); #1;
    bus_b.we = 0; bus_b.re = 0; bus_b.flush = 0; bus_b.clr_err = 0;
  endtask

  task automatic a_levels(input string tag, input int cnt);
    check({tag, "_count"}, 32'(bus_a.count), 32'(cnt));
    check({tag, "_empty"}, 32'(bus_a.empty), 32'(cnt == 0));
    check({tag, "_full"},  32'(bus_a.full),  32'(cnt == 16));
    check({tag, "_ae"},    32'(bus_a.almost_empty), 32'(cnt <= 4));
    check({tag, "_af"},    32'(bus_a.almost_full),  32'(cnt >= 12));
  endtask

  // FWFT monitor: data is valid whenever a pop is presented on a non-empty FIFO.
  always @(negedge clk) begin
    logic [7:0] e;
    if (rst_a === 1'b0 && bus_a.re === 1'b1 && bus_a.empty === 1'b0 && bus_a.flush !== 1'b1) begin
      n_checks++;
      if (exp_a.size() == 0) begin
        $display("FAIL mon_a: popped 0x%0h, required no pop", bus_a.rdata);
      end else begin
        e = exp_a.pop_front();
        if (bus_a.rdata === e) n_pass++;
        else $display("FAIL mon_a: rdata 0x%0h, required 0x%0h", bus_a.rdata, e);
      end
    end
  end

  // Registered-read monitor: data appears the cycle after an accepted pop.
  always @(posedge clk)
    pend_b <= (rst_b === 1'b0 && bus_b.re === 1'b1 && bus_b.empty === 1'b0 &&
               bus_b.flush !== 1'b1);

  always @(negedge clk) begin
    logic [7:0] e;
    if (pend_b) begin
      n_checks++;
      if (exp_b.size() == 0) begin
        $display("FAIL mon_b: popped 0x%0h, required no pop", bus_b.rdata);
      end else begin
        e = exp_b.pop_front();
        if (bus_b.rdata === e) n_pass++;
        else $display("FAIL mon_b: rdata 0x%0h, required 0x%0h", bus_b.rdata, e);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "timeout");
  end

  initial begin
    rst_a = 1; rst_b = 1;
    bus_a.we = 0; bus_a.wdata = 0; bus_a.re = 0; bus_a.flush = 0; bus_a.clr_err = 0;
    bus_b.we = 0; bus_b.wdata = 0; bus_b.re = 0; bus_b.flush = 0; bus_b.clr_err = 0;
    repeat (2) @(posedge clk);
    #1; rst_a = 0; rst_b = 0;
    @(posedge clk); #1;

    // Reset state
    a_levels("rst_a", 0);
    check("rst_a_ovf", 32'(bus_a.overflow), 0);
    check("rst_a_udf", 32'(bus_a.underflow), 0);

    // Fill to full, watching watermarks at every level
    for (int i = 0; i < 16; i++) begin
      a_op(1, 8'(i), 0, 0, 0);
      a_levels($sformatf("fill%0d", i + 1), i + 1);
    end

    // Push while full is dropped
    a_op(1, 8'hAA, 0, 0, 0);
    check("ovf_set", 32'(bus_a.overflow), 1);
    check("ovf_count", 32'(bus_a.count), 16);

    for (int i = 0; i < 16; i++) begin
      exp_a.push_back(8'(i));
      a_op(0, 0, 1, 0, 0);
    end
    a_levels("drain", 0);

    // Pop on empty
    a_op(0, 0, 1, 0, 0);
    check("udf_set", 32'(bus_a.underflow), 1);
    check("udf_count", 32'(bus_a.count), 0);
    a_op(0, 0, 1, 0, 1);
    check("udf_set_wins", 32'(bus_a.underflow), 1);
    a_op(0, 0, 0, 0, 1);
    check("udf_clr", 32'(bus_a.underflow), 0);
    check("ovf_clr", 32'(bus_a.overflow), 0);

    // Simultaneous push/pop while full
    for (int i = 0; i < 16; i++) a_op(1, 8'(i), 0, 0, 0);
    check("refill_full", 32'(bus_a.full), 1);
    exp_a.push_back(8'h00);
    a_op(1, 8'h55, 1, 0, 0);
    check("wr_full_count", 32'(bus_a.count), 16);
    check("wr_full_no_ovf", 32'(bus_a.overflow), 0);
    for (int i = 1; i < 16; i++) begin
      exp_a.push_back(8'(i));
      a_op(0, 0, 1, 0, 0);
    end
    exp_a.push_back(8'h55);
    a_op(0, 0, 1, 0, 0);
    a_levels("wrap_drain", 0);

    // Simultaneous push/pop while empty, then streaming across pointer wrap
    a_op(1, 8'h33, 1, 0, 0);
    check("wr_empty_count", 32'(bus_a.count), 1);
    check("wr_empty_udf", 32'(bus_a.underflow), 1);
    for (int k = 0; k < 40; k++) begin
      exp_a.push_back((k == 0) ? 8'h33 : 8'(8'h40 + k - 1));
      a_op(1, 8'(8'h40 + k), 1, 0, 0);
      if (bus_a.count !== 5'd1) check($sformatf("stream_count%0d", k), 32'(bus_a.count), 1);
    end
    check("stream_count_end", 32'(bus_a.count), 1);
    exp_a.push_back(8'h67);
    a_op(0, 0, 1, 0, 0);
    check("stream_empty", 32'(bus_a.empty), 1);

    // Registered-read instance
    check("rst_b_rdata", 32'(bus_b.rdata), 0);
    check("rst_b_count", 32'(bus_b.count), 0);
    b_op(1, 8'h11, 0, 0, 0);
    b_op(1, 8'h22, 0, 0, 0);
    exp_b.push_back(8'h11);
    b_op(0, 0, 1, 0, 0);
    b_op(0, 0, 0, 0, 0);
    b_op(0, 0, 0, 0, 0);
    check("b_rdata_hold", 32'(bus_b.rdata), 32'h11);
    exp_b.push_back(8'h22);
    b_op(0, 0, 1, 0, 0);
    b_op(0, 0, 0, 0, 0);
    check("b_empty", 32'(bus_b.empty), 1);

    // Flush mid-stream with concurrent requests
    b_op(1, 8'h01, 0, 0, 0);
    b_op(1, 8'h02, 0, 0, 0);
    b_op(1, 8'h03, 0, 0, 0);
    check("b_pre_flush", 32'(bus_b.count), 3);
    b_op(1, 8'h04, 1, 1, 0);
    check("flush_count", 32'(bus_b.count), 0);
    check("flush_empty", 32'(bus_b.empty), 1);
    check("flush_flags", 32'({bus_b.overflow, bus_b.underflow}), 0);
    check("flush_rdata_hold", 32'(bus_b.rdata), 32'h22);
    b_op(1, 8'h77, 0, 0, 0);
    exp_b.push_back(8'h77);
    b_op(0, 0, 1, 0, 0);
    b_op(0, 0, 1, 0, 0);
    check("b_udf", 32'(bus_b.underflow), 1);

    // Async reset in the middle of a push burst
    b_op(1, 8'hA0, 0, 0, 0);
    b_op(1, 8'hA1, 0, 0, 0);
    bus_b.we = 1; bus_b.wdata = 8'hA2;
    @(posedge clk); #2;
    rst_b = 1;
    #1;
    check("arst_count", 32'(bus_b.count), 0);
    check("arst_empty", 32'(bus_b.empty), 1);
    check("arst_ae", 32'(bus_b.almost_empty), 1);
    check("arst_full_af", 32'({bus_b.full, bus_b.almost_full}), 0);
    check("arst_flags", 32'({bus_b.overflow, bus_b.underflow}), 0);
    check("arst_rdata", 32'(bus_b.rdata), 0);
    bus_b.we = 0;
    @(negedge clk);
    rst_b = 0;
    @(posedge clk); #1;
    check("post_arst_count", 32'(bus_b.count), 0);

    repeat (2) @(posedge clk);
    check("exp_a_drained", 32'(exp_a.size()), 0);
    check("exp_b_drained", 32'(exp_b.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
